// File: rtl/mips_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_pkg: opcodes, ALU op codes, FSM states and mux encodings    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mips_pkg;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_ORI   = 6'b001101;
    localparam logic [5:0] C_OP_LUI   = 6'b001111;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    localparam logic [5:0] C_FN_ADDU  = 6'b100001;
    localparam logic [5:0] C_FN_SUBU  = 6'b100011;

    // Shared with the ALU
    localparam logic [3:0] C_ALU_ADDU = 4'b0000;
    localparam logic [3:0] C_ALU_SUBU = 4'b0001;
    localparam logic [3:0] C_ALU_OR   = 4'b0010;

    localparam logic [1:0] C_PC_ALU    = 2'b00;
    localparam logic [1:0] C_PC_ALUOUT = 2'b01;
    localparam logic [1:0] C_PC_JUMP   = 2'b10;

    localparam logic [1:0] C_SRCB_RT   = 2'b00;
    localparam logic [1:0] C_SRCB_FOUR = 2'b01;
    localparam logic [1:0] C_SRCB_IMM  = 2'b10;
    localparam logic [1:0] C_SRCB_BOFF = 2'b11;

    localparam logic [1:0] C_EXT_ZERO  = 2'b00;
    localparam logic [1:0] C_EXT_SIGN  = 2'b01;
    localparam logic [1:0] C_EXT_HI    = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC_R  = 4'd2,
        ST_ALUWB_R = 4'd3,
        ST_EXEC_I  = 4'd4,
        ST_ALUWB_I = 4'd5,
        ST_MEMADR  = 4'd6,
        ST_MEMRD   = 4'd7,
        ST_MEMWB   = 4'd8,
        ST_MEMWR   = 4'd9,
        ST_BRANCH  = 4'd10,
        ST_JUMP    = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        CLS_R_ADDU  = 4'd0,
        CLS_R_SUBU  = 4'd1,
        CLS_ORI     = 4'd2,
        CLS_LUI     = 4'd3,
        CLS_LW      = 4'd4,
        CLS_SW      = 4'd5,
        CLS_BEQ     = 4'd6,
        CLS_J       = 4'd7,
        CLS_ILLEGAL = 4'd8
    } instr_class_t;

endpackage
`default_nettype wire

// File: rtl/mc_control_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_control_if: IR fields / Zero in, datapath controls out        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface mc_control_if #(
    parameter int ALUOP_W = 4,
    parameter int STATE_W = 4
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               pc_en;
    logic [1:0]         pc_src;
    logic               i_or_d;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         ext_op;
    logic [ALUOP_W-1:0] alu_op;
    logic               instr_done;
    logic               illegal;
    logic [STATE_W-1:0] dbg_state;

    modport master (
        input  op, funct, zero,
        output pc_en, pc_src, i_or_d, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op, instr_done,
               illegal, dbg_state
    );

    modport slave (
        output op, funct, zero,
        input  pc_en, pc_src, i_or_d, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op, instr_done,
               illegal, dbg_state
    );
endinterface
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_decode: op/funct to instruction class (purely combinational)  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mc_decode
    import mips_pkg::*;
(
    input  logic [5:0]   i_op,
    input  logic [5:0]   i_funct,
    output instr_class_t o_class
);
    always_comb begin
        o_class = CLS_ILLEGAL;
        case (i_op)
            C_OP_RTYPE: begin
                if (i_funct == C_FN_ADDU)      o_class = CLS_R_ADDU;
                else if (i_funct == C_FN_SUBU) o_class = CLS_R_SUBU;
            end
            C_OP_ORI: o_class = CLS_ORI;
            C_OP_LUI: o_class = CLS_LUI;
            C_OP_LW:  o_class = CLS_LW;
            C_OP_SW:  o_class = CLS_SW;
            C_OP_BEQ: o_class = CLS_BEQ;
            C_OP_J:   o_class = CLS_J;
            default:  o_class = CLS_ILLEGAL;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_control: multicycle MIPS main control FSM                     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mc_control
    import mips_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int STATE_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    mc_control_if.master bus
);
    state_t       r_state;
    state_t       w_next_state;
    instr_class_t w_class;

    mc_decode u_decode (
        .i_op    (bus.op),
        .i_funct (bus.funct),
        .o_class (w_class)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_FETCH;
        else       r_state <= w_next_state;
    end

    assign bus.dbg_state = STATE_W'(r_state);

    always_comb begin
        w_next_state   = ST_FETCH;
        bus.pc_en      = 1'b0;
        bus.pc_src     = C_PC_ALU;
        bus.i_or_d     = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = C_SRCB_RT;
        bus.ext_op     = C_EXT_SIGN;
        bus.alu_op     = ALUOP_W'(C_ALU_ADDU);
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;

        case (r_state)
            ST_FETCH: begin
                bus.ir_write  = 1'b1;
                bus.alu_src_b = C_SRCB_FOUR;
                bus.pc_en     = 1'b1;
                w_next_state  = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target is computed speculatively into ALUOut here
                bus.alu_src_b = C_SRCB_BOFF;
                case (w_class)
                    CLS_R_ADDU, CLS_R_SUBU: w_next_state = ST_EXEC_R;
                    CLS_ORI, CLS_LUI:       w_next_state = ST_EXEC_I;
                    CLS_LW, CLS_SW:         w_next_state = ST_MEMADR;
                    CLS_BEQ:                w_next_state = ST_BRANCH;
                    CLS_J:                  w_next_state = ST_JUMP;
                    default: begin
                        bus.illegal    = 1'b1;
                        bus.instr_done = 1'b1;
                        w_next_state   = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = C_SRCB_RT;
                bus.alu_op    = (w_class == CLS_R_SUBU) ? ALUOP_W'(C_ALU_SUBU)
                                                        : ALUOP_W'(C_ALU_ADDU);
                w_next_state  = ST_ALUWB_R;
            end
            ST_ALUWB_R: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
            end
            ST_EXEC_I: begin
                // lui is imm<<16 OR rs, relying on the assembler to use rs=$0
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = C_SRCB_IMM;
                bus.alu_op    = ALUOP_W'(C_ALU_OR);
                bus.ext_op    = (w_class == CLS_LUI) ? C_EXT_HI : C_EXT_ZERO;
                w_next_state  = ST_ALUWB_I;
            end
            ST_ALUWB_I: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            ST_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = C_SRCB_IMM;
                w_next_state  = (w_class == CLS_LW) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                bus.i_or_d   = 1'b1;
                w_next_state = ST_MEMWB;
            end
            ST_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                bus.i_or_d     = 1'b1;
                bus.mem_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = C_SRCB_RT;
                bus.alu_op     = ALUOP_W'(C_ALU_SUBU);
                bus.pc_src     = C_PC_ALUOUT;
                bus.pc_en      = bus.zero;
                bus.instr_done = 1'b1;
            end
            ST_JUMP: begin
                bus.pc_src     = C_PC_JUMP;
                bus.pc_en      = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: w_next_state = ST_FETCH;
        endcase

        // Reset suppresses every side effect and parks selects at FETCH values
        if (reset) begin
            bus.pc_en      = 1'b0;
            bus.ir_write   = 1'b0;
            bus.mem_write  = 1'b0;
            bus.reg_write  = 1'b0;
            bus.instr_done = 1'b0;
            bus.illegal    = 1'b0;
            bus.pc_src     = C_PC_ALU;
            bus.i_or_d     = 1'b0;
            bus.reg_dst    = 1'b0;
            bus.mem_to_reg = 1'b0;
            bus.alu_src_a  = 1'b0;
            bus.alu_src_b  = C_SRCB_FOUR;
            bus.ext_op     = C_EXT_SIGN;
            bus.alu_op     = ALUOP_W'(C_ALU_ADDU);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mc_control: directed self-checking bench for mc_control       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mc_control;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    mc_control_if #(.ALUOP_W(4), .STATE_W(4)) bus ();

    mc_control #(.ALUOP_W(4), .STATE_W(4)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if ({bus.pc_en, bus.ir_write, bus.reg_write, bus.mem_write} !== 4'b0000)
                $display("FAIL reset_enables cyc%0d: got %b want 0000", i,
                         {bus.pc_en, bus.ir_write, bus.reg_write, bus.mem_write});
            else n_pass++;
            n_total++;
            if ({bus.dbg_state, bus.alu_src_b} !== 6'b0000_01)
                $display("FAIL reset_state cyc%0d: got %b want 000001", i,
                         {bus.dbg_state, bus.alu_src_b});
            else n_pass++;
        end
        rst = 1'b0;
        #1;
        n_total++;
        if ({bus.dbg_state, bus.pc_en, bus.ir_write} !== 6'b0000_11)
            $display("FAIL reset_release: got %b want 000011",
                     {bus.dbg_state, bus.pc_en, bus.ir_write});
        else n_pass++;
    endtask

    task automatic test_subu;
        bus.op = 6'b000000; bus.funct = 6'b100011;
        n_total++;
        if ({bus.dbg_state, bus.alu_src_b, bus.alu_op} !== 10'b0000_01_0000)
            $display("FAIL subu_fetch: got %b want 0000010000",
                     {bus.dbg_state, bus.alu_src_b, bus.alu_op});
        else n_pass++;
        tick();
        n_total++;
        if ({bus.dbg_state, bus.alu_src_a, bus.alu_src_b, bus.ext_op} !== 9'b0001_0_11_01)
            $display("FAIL subu_decode: got %b want 000101101",
                     {bus.dbg_state, bus.alu_src_a, bus.alu_src_b, bus.ext_op});
        else n_pass++;
        tick();
        n_total++;
        if ({bus.dbg_state, bus.alu_op, bus.alu_src_a, bus.alu_src_b} !== 11'b0010_0001_1_00)
            $display("FAIL subu_exec: got %b want 00100001100",
                     {bus.dbg_state, bus.alu_op, bus.alu_src_a, bus.alu_src_b});
        else n_pass++;
        tick();
        n_total++;
        if ({bus.dbg_state, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done}
            !== 8'b0011_1101)
            $display("FAIL subu_wb: got %b want 00111101",
                     {bus.dbg_state, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done});
        else n_pass++;
        tick();
    endtask

    task automatic test_lw_sw;
        bus.op = 6'b100011;
        tick();
        tick();
        n_total++;
        if ({bus.dbg_state, bus.alu_src_a, bus.alu_src_b, bus.ext_op} !== 9'b0110_1_10_01)
            $display("FAIL lw_memadr: got %b want 011011001",
                     {bus.dbg_state, bus.alu_src_a, bus.alu_src_b, bus.ext_op});
        else n_pass++;
        tick();
        n_total++;
        if ({bus.dbg_state, bus.i_or_d, bus.reg_write, bus.mem_write} !== 7'b0111_100)
            $display("FAIL lw_memrd: got %b want 0111100",
                     {bus.dbg_state, bus.i_or_d, bus.reg_write, bus.mem_write});
        else n_pass++;
        tick();
        n_total++;
        if ({bus.dbg_state, bus.reg_write, bus.mem_to_reg, bus.reg_dst, bus.instr_done}
            !== 8'b1000_1101)
            $display("FAIL lw_memwb: got %b want 10001101",
                     {bus.dbg_state, bus.reg_write, bus.mem_to_reg, bus.reg_dst, bus.instr_done});
        else n_pass++;
        tick();
        bus.op = 6'b101011;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (bus.mem_write !== 1'b0)
                $display("FAIL sw_early_write cyc%0d: got %b want 0", i, bus.mem_write);
            else n_pass++;
            tick();
        end
        n_total++;
        if ({bus.dbg_state, bus.mem_write, bus.i_or_d, bus.instr_done, bus.reg_write}
            !== 8'b1001_1110)
            $display("FAIL sw_memwr: got %b want 10011110",
                     {bus.dbg_state, bus.mem_write, bus.i_or_d, bus.instr_done, bus.reg_write});
        else n_pass++;
        tick();
    endtask

    task automatic test_beq;
        logic [3:0] exp;
        bus.op = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            bus.zero = z[0];
            exp = {z[0], 2'b01, 1'b1};
            tick();
            tick();
            n_total++;
            if ({bus.dbg_state, bus.alu_op, bus.alu_src_a} !== 9'b1010_0001_1)
                $display("FAIL beq_branch_alu z=%0d: got %b want 101000011", z,
                         {bus.dbg_state, bus.alu_op, bus.alu_src_a});
            else n_pass++;
            n_total++;
            if ({bus.pc_en, bus.pc_src, bus.instr_done} !== exp)
                $display("FAIL beq_branch_pc z=%0d: got %b want %b", z,
                         {bus.pc_en, bus.pc_src, bus.instr_done}, exp);
            else n_pass++;
            tick();
            n_total++;
            if (bus.dbg_state !== 4'd0)
                $display("FAIL beq_return z=%0d: got %0d want 0", z, bus.dbg_state);
            else n_pass++;
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_imm;
        bus.op = 6'b001111;
        tick();
        tick();
        n_total++;
        if ({bus.dbg_state, bus.alu_op, bus.ext_op, bus.alu_src_b, bus.alu_src_a}
            !== 13'b0100_0010_10_10_1)
            $display("FAIL lui_exec: got %b want 0100001010101",
                     {bus.dbg_state, bus.alu_op, bus.ext_op, bus.alu_src_b, bus.alu_src_a});
        else n_pass++;
        tick();
        n_total++;
        if ({bus.dbg_state, bus.reg_write, bus.reg_dst, bus.instr_done} !== 7'b0101_101)
            $display("FAIL lui_wb: got %b want 0101101",
                     {bus.dbg_state, bus.reg_write, bus.reg_dst, bus.instr_done});
        else n_pass++;
        tick();
        bus.op = 6'b001101;
        tick();
        tick();
        n_total++;
        if ({bus.dbg_state, bus.alu_op, bus.ext_op} !== 10'b0100_0010_00)
            $display("FAIL ori_exec: got %b want 0100001000",
                     {bus.dbg_state, bus.alu_op, bus.ext_op});
        else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_jump;
        bus.op = 6'b000010;
        tick();
        tick();
        n_total++;
        if ({bus.dbg_state, bus.pc_src, bus.pc_en, bus.instr_done} !== 8'b1011_10_1_1)
            $display("FAIL j_jump: got %b want 10111011",
                     {bus.dbg_state, bus.pc_src, bus.pc_en, bus.instr_done});
        else n_pass++;
        tick();
    endtask

    task automatic test_illegal;
        bus.op = 6'b111111;
        tick();
        n_total++;
        if ({bus.illegal, bus.instr_done, bus.pc_en, bus.ir_write, bus.reg_write, bus.mem_write}
            !== 6'b110000)
            $display("FAIL illegal_decode: got %b want 110000",
                     {bus.illegal, bus.instr_done, bus.pc_en, bus.ir_write,
                      bus.reg_write, bus.mem_write});
        else n_pass++;
        tick();
        n_total++;
        if ({bus.dbg_state, bus.illegal} !== 5'b0000_0)
            $display("FAIL illegal_return: got %b want 00000", {bus.dbg_state, bus.illegal});
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        bus.op = 6'b100011;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_total++;
        if ({bus.dbg_state, bus.pc_en, bus.ir_write, bus.reg_write, bus.mem_write, bus.i_or_d}
            !== 9'b0111_00000)
            $display("FAIL midreset_memrd: got %b want 011100000",
                     {bus.dbg_state, bus.pc_en, bus.ir_write, bus.reg_write,
                      bus.mem_write, bus.i_or_d});
        else n_pass++;
        tick();
        n_total++;
        if ({bus.dbg_state, bus.reg_write} !== 5'b0000_0)
            $display("FAIL midreset_next: got %b want 00000", {bus.dbg_state, bus.reg_write});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if ({bus.dbg_state, bus.pc_en} !== 5'b0000_1)
            $display("FAIL midreset_release: got %b want 00001", {bus.dbg_state, bus.pc_en});
        else n_pass++;
    endtask

    task automatic test_cpi;
        logic [5:0] ops [9];
        logic [5:0] fns [9];
        int         cpi [9];
        int         cyc;
        logic       both;
        ops = '{6'b000000, 6'b000000, 6'b001101, 6'b001111, 6'b100011,
                6'b101011, 6'b000100, 6'b000010, 6'b111111};
        fns = '{6'b100001, 6'b100011, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};
        cpi = '{4, 4, 4, 4, 5, 4, 3, 3, 2};
        for (int k = 0; k < 9; k++) begin
            bus.op = ops[k];
            bus.funct = fns[k];
            cyc = 1;
            both = bus.reg_write & bus.mem_write;
            while (bus.instr_done !== 1'b1 && cyc < 10) begin
                tick();
                cyc++;
                both = both | (bus.reg_write & bus.mem_write);
            end
            n_total++;
            if (cyc != cpi[k] || bus.instr_done !== 1'b1)
                $display("FAIL cpi op=%b: got %0d cycles want %0d", ops[k], cyc, cpi[k]);
            else n_pass++;
            n_total++;
            if (both !== 1'b0)
                $display("FAIL write_exclusive op=%b: got %b want 0", ops[k], both);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        bus.op    = 6'b000000;
        bus.funct = 6'b100001;
        bus.zero  = 1'b0;
        test_reset();
        test_subu();
        test_lw_sw();
        test_beq();
        test_imm();
        test_jump();
        test_illegal();
        test_reset_mid();
        test_cpi();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle MIPS main control FSM, sitting directly upstream of the datapath ALU.
- Decodes the IR opcode/funct fields and sequences FETCH/DECODE/EXECUTE/MEM/WB.
- Drives the ALU operation code and datapath mux selects and write enables.
- Consumes the ALU Zero flag to resolve beq.
- Supported subset: addu, subu, ori, lui, lw, sw, beq, j.

Parameters:
- ALUOP_W, 4, width of alu_op (encodings: ADDU=4'b0000, SUBU=4'b0001, OR=4'b0010).
- STATE_W, 4, width of the state register and the dbg_state port.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU Zero flag (A-B==0).
- pc_en  out  1  PC register load enable.
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut register, 10 jump target {PC[31:28],IR[25:0],2'b00}.
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  write register: 0 rt, 1 rd.
- mem_to_reg  out  1  write-back data: 0 ALUOut, 1 MDR.
- alu_src_a  out  1  ALU A input: 0 PC, 1 rs data.
- alu_src_b  out  2  ALU B input: 00 rt data, 01 const 4, 10 extended imm, 11 sign-extended imm<<2.
- ext_op  out  2  immediate extender: 00 zero-extend, 01 sign-extend, 10 imm<<16.
- alu_op  out  ALUOP_W  operation code to the ALU.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal  out  1  one-cycle pulse in DECODE when op/funct is unsupported.
- dbg_state  out  STATE_W  current state.

Behaviour:
- Decode style:
  - State register is updated on the rising clk edge.
  - All outputs are combinational from state; exceptions: pc_en in BRANCH (depends on zero) and illegal (depends on op/funct).
- Reset:
  - reset high at an edge puts state in FETCH.
  - While reset is high, pc_en, ir_write, mem_write, reg_write, instr_done and illegal are forced 0.
  - Mux selects take their FETCH values during reset.
  - Reset mid-instruction abandons it with no partial write.
- Default output values (any state not listed): all enables 0, selects 0, alu_op=ADDU, ext_op=01.
- States and their outputs:
  - FETCH: i_or_d=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=ADDU, pc_src=00, pc_en=1. Next: DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, ext_op=01, alu_op=ADDU (branch target into ALUOut).
    - Next: R-type (op=000000, funct 100001/100011) -> EXEC_R; ori (001101) / lui (001111) -> EXEC_I; lw (100011) / sw (101011) -> MEMADR; beq (000100) -> BRANCH; j (000010) -> JUMP.
    - Otherwise: illegal=1, instr_done=1, next FETCH.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op = ADDU for funct 100001, SUBU for 100011. Next: ALUWB_R.
  - ALUWB_R: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next: FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=OR, ext_op = 00 for ori, 10 for lui. The lui sequence relies on rs=$0 per the assembler convention. Next: ALUWB_I.
  - ALUWB_I: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next: FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=10, ext_op=01, alu_op=ADDU. Next: MEMRD (lw) or MEMWR (sw).
  - MEMRD: i_or_d=1. Next: MEMWB.
  - MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next: FETCH.
  - MEMWR: i_or_d=1, mem_write=1, instr_done=1. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUBU, pc_src=01, pc_en=zero, instr_done=1. Next: FETCH.
  - JUMP: pc_src=10, pc_en=1, instr_done=1. Next: FETCH.
- CPI: R/ori/lui 4, lw 5, sw 4, beq 3, j 3, illegal 2.
- Unused state encodings go to FETCH on the next edge, with all enables 0.
- Exactly one of reg_write/mem_write may be high in any cycle.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct localparams;
  - ALUOp encodings ADDU/SUBU/OR (shared with the ALU);
  - state encodings;
  - pc_src, alu_src_b and ext_op encodings.
- One sub-module, mc_decode: combinational op/funct -> instruction class (R_ADDU, R_SUBU, ORI, LUI, LW, SW, BEQ, J, ILLEGAL), used by the DECODE transitions and EXEC_R alu_op selection.

Test Plan:
- Hold reset 3 cycles, then release -> during reset pc_en=ir_write=reg_write=mem_write=0; first cycle after release dbg_state=FETCH with pc_en=1, ir_write=1.
- op=000000, funct=100011 (subu) -> states FETCH, DECODE, EXEC_R (alu_op=0001), ALUWB_R (reg_write=1, reg_dst=1); instr_done on cycle 4.
- op=100011 (lw) -> 5 cycles; MEMRD i_or_d=1; MEMWB mem_to_reg=1, reg_write=1. Then op=101011 (sw) -> 4 cycles, mem_write=1 only in MEMWR.
- op=000100 (beq) with zero=1 -> BRANCH pc_en=1, pc_src=01; repeat with zero=0 -> pc_en=0; both 3 cycles.
- op=001111 (lui) -> EXEC_I alu_op=0010, ext_op=10, alu_src_b=10; op=001101 (ori) -> ext_op=00. op=000010 (j) -> JUMP pc_src=10, pc_en=1.
- op=111111 -> illegal=1 in DECODE, no write enables, FETCH next. Reset asserted in MEMRD -> FETCH next cycle, no reg_write.
